// File: rtl/ex_alu_arbiter_pkg.sv
// Shared ALU definitions for the EX-stage ALU arbiter: opcode width, opcodes
// and a width helper for requester indices.
package ex_alu_arbiter_pkg;

  localparam int ALUOP_L = 5;

  localparam logic [ALUOP_L-1:0] ALU_ADD = 5'd0;
  localparam logic [ALUOP_L-1:0] ALU_SUB = 5'd1;
  localparam logic [ALUOP_L-1:0] ALU_AND = 5'd2;
  localparam logic [ALUOP_L-1:0] ALU_OR  = 5'd3;
  localparam logic [ALUOP_L-1:0] ALU_XOR = 5'd4;

  // A single requester still needs a 1-bit index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ex_alu_arbiter_rr_arb_pick.sv
// Round-robin pick: first set request bit scanning upward from ptr with wrap.
// Purely combinational; returns one-hot pick, its index and an any-request flag.
module ex_alu_arbiter_rr_arb_pick
  import ex_alu_arbiter_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
    pick = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/ex_alu_arbiter.sv
// Shares one multi-cycle ALU (run/ack handshake) between NREQ EX-stage requesters
// with round-robin grant, one-cycle done pulse and a sticky no-ack timeout flag.
module ex_alu_arbiter
  import ex_alu_arbiter_pkg::*;
#(
  parameter int REG_SZ  = 32,
  parameter int OP_W    = ALUOP_L,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*OP_W-1:0]   req_op,
  input  logic [NREQ*REG_SZ-1:0] req_opr1,
  input  logic [NREQ*REG_SZ-1:0] req_opr2,
  input  logic [NREQ-1:0]        req_c,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [REG_SZ-1:0]      ans,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   alu_run,
  output logic [OP_W-1:0]        alu_op,
  output logic [REG_SZ-1:0]      alu_opr1,
  output logic [REG_SZ-1:0]      alu_opr2,
  output logic                   alu_c,
  input  logic [REG_SZ-1:0]      alu_ans,
  input  logic                   alu_ack
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_next;
  logic [CNT_W-1:0] cnt;
  logic             ack_q;
  logic             ack_rise;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  ex_alu_arbiter_rr_arb_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // An ack that is already high when WAIT starts is stale; only a fresh edge counts.
  assign ack_rise = alu_ack & ~ack_q;
  assign ptr_next = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      idx_q       <= '0;
      cnt         <= '0;
      ack_q       <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      ans         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      alu_run     <= 1'b0;
      alu_op      <= '0;
      alu_opr1    <= '0;
      alu_opr2    <= '0;
      alu_c       <= 1'b0;
    end else begin
      ack_q <= alu_ack;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            idx_q    <= pick_idx;
            gnt      <= pick;
            alu_op   <= req_op[int'(pick_idx)*OP_W +: OP_W];
            alu_opr1 <= req_opr1[int'(pick_idx)*REG_SZ +: REG_SZ];
            alu_opr2 <= req_opr2[int'(pick_idx)*REG_SZ +: REG_SZ];
            alu_c    <= req_c[pick_idx];
            alu_run  <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_run <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (ack_rise) begin
            ans   <= alu_ans;
            done  <= gnt;
            ptr   <= ptr_next;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            // Forced completion keeps the requester from stalling forever.
            ans         <= '0;
            done        <= gnt;
            timeout_err <= 1'b1;
            ptr         <= ptr_next;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // DONE masks the finished requester's req for the cycle it takes to drop it.
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// Self-checking bench for ex_alu_arbiter: directed scenarios plus randomized
// request mixes, checked against a transaction-level reference model.
module tb_ex_alu_arbiter;
  import ex_alu_arbiter_pkg::*;

  localparam int REG_SZ  = 32;
  localparam int OP_W    = ALUOP_L;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [NREQ*REG_SZ-1:0] req_opr1;
  logic [NREQ*REG_SZ-1:0] req_opr2;
  logic [NREQ-1:0]        req_c;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [REG_SZ-1:0]      ans;
  logic                   busy;
  logic                   timeout_err;
  logic                   alu_run;
  logic [OP_W-1:0]        alu_op;
  logic [REG_SZ-1:0]      alu_opr1;
  logic [REG_SZ-1:0]      alu_opr2;
  logic                   alu_c;
  logic [REG_SZ-1:0]      alu_ans;
  logic                   alu_ack;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;
  bit terr_m      = 1'b0;

  always #5 clk = ~clk;

  ex_alu_arbiter #(
    .REG_SZ (REG_SZ),
    .OP_W   (OP_W),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_opr1   (req_opr1),
    .req_opr2   (req_opr2),
    .req_c      (req_c),
    .gnt        (gnt),
    .done       (done),
    .ans        (ans),
    .busy       (busy),
    .timeout_err(timeout_err),
    .alu_run    (alu_run),
    .alu_op     (alu_op),
    .alu_opr1   (alu_opr1),
    .alu_opr2   (alu_opr2),
    .alu_c      (alu_c),
    .alu_ans    (alu_ans),
    .alu_ack    (alu_ack)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behaviour of the external ALU the bench plays.
  function automatic logic [REG_SZ-1:0] alu_model(input logic [OP_W-1:0] op,
                                                  input logic [REG_SZ-1:0] a,
                                                  input logic [REG_SZ-1:0] b,
                                                  input logic c);
    case (op)
      ALU_ADD: return a + b + REG_SZ'(c);
      ALU_SUB: return a - b - REG_SZ'(c);
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return a;
    endcase
  endfunction

  // Who is served next: the first active requester at or after the pointer, wrapping.
  function automatic int pick_model(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic load(input int i, input logic [OP_W-1:0] op, input logic [REG_SZ-1:0] a,
                      input logic [REG_SZ-1:0] b, input logic c);
    req_op[i*OP_W +: OP_W]       = op;
    req_opr1[i*REG_SZ +: REG_SZ] = a;
    req_opr2[i*REG_SZ +: REG_SZ] = b;
    req_c[i]                     = c;
    req[i]                       = 1'b1;
  endtask

  task automatic load_rand(input int i);
    load(i, OP_W'($urandom_range(0, 4)), $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // One transaction. mode 0: ALU acks dly cycles after run; mode 1: ALU never acks;
  // mode 2: ack is stuck high beforehand, drops at dly and rises on the next cycle.
  task automatic transact(input int dly, input int mode, input bit hold);
    int idx, n, w, exp_n;
    bit early;
    logic [OP_W-1:0]   e_op;
    logic [REG_SZ-1:0] e_a, e_b, e_ans;
    logic              e_c;
    idx   = pick_model(req, ptr_m);
    e_op  = req_op[idx*OP_W +: OP_W];
    e_a   = req_opr1[idx*REG_SZ +: REG_SZ];
    e_b   = req_opr2[idx*REG_SZ +: REG_SZ];
    e_c   = req_c[idx];
    e_ans = (mode == 1) ? '0 : alu_model(e_op, e_a, e_b, e_c);
    w = 0;
    do begin tick(); w++; end while (alu_run !== 1'b1 && w < 8);
    check("issue_latency", w, 1);
    check("gnt", gnt, NREQ'(1) << idx);
    check("busy", busy, 1);
    check("alu_op", alu_op, e_op);
    check("alu_opr1", alu_opr1, e_a);
    check("alu_opr2", alu_opr2, e_b);
    check("alu_c", alu_c, e_c);
    // The requester changes its inputs after the grant; the latched copy must not move.
    req_op[idx*OP_W +: OP_W]       = ~e_op;
    req_opr1[idx*REG_SZ +: REG_SZ] = ~e_a;
    req_opr2[idx*REG_SZ +: REG_SZ] = $urandom;
    req_c[idx]                     = ~e_c;
    tick();
    n = 1;
    check("run_pulse", alu_run, 0);
    early = (done != '0);
    while (n < dly) begin tick(); n++; early |= (done != '0); end
    if (mode == 2) begin
      alu_ack = 1'b0;
      tick();
      n++;
      early |= (done != '0);
    end
    check("early_done", early, 0);
    if (mode == 1) exp_n = TIMEOUT + 1;
    else begin
      alu_ans = e_ans;
      alu_ack = 1'b1;
      exp_n   = n + 1;
    end
    while (done == '0 && n < 3*TIMEOUT) begin tick(); n++; end
    check("done_latency", n, exp_n);
    check("done", done, NREQ'(1) << idx);
    check("ans", ans, e_ans);
    if (mode == 1) terr_m = 1'b1;
    check("timeout_err", timeout_err, terr_m);
    check("alu_op_held", alu_op, e_op);
    check("alu_opr1_held", alu_opr1, e_a);
    check("alu_c_held", alu_c, e_c);
    check("gnt_held", gnt, NREQ'(1) << idx);
    ptr_m   = (idx + 1) % NREQ;
    alu_ack = 1'b0;
    alu_ans = $urandom;
    if (!hold) req[idx] = 1'b0;
    tick();
    check("done_pulse", done, 0);
    check("gnt_clear", gnt, 0);
    check("busy_clear", busy, 0);
    check("ans_hold", ans, e_ans);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    req      = '0;
    req_op   = '0;
    req_opr1 = '0;
    req_opr2 = '0;
    req_c    = '0;
    alu_ans  = '0;
    alu_ack  = 1'b0;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_run", alu_run, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b1;
    tick();

    // Single ADD on port 0, ack three cycles after run.
    load(0, ALU_ADD, 32'd5, 32'd7, 1'b0);
    transact(3, 0, 1'b0);
    check("t1_ans", ans, 32'd12);

    // SUB with carry on port 0; operands scrambled after grant inside transact.
    load(0, ALU_SUB, 32'd100, 32'd30, 1'b1);
    transact(2, 0, 1'b0);
    check("t6_ans", ans, 32'd69);

    // Both requesters held continuously: grants must alternate.
    load_rand(0);
    load_rand(1);
    for (int t = 0; t < 4; t++) transact(2, 0, 1'b1);
    req = '0;

    // Randomized request mixes and ack delays.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) load_rand(i);
      if (req == '0) load_rand($urandom_range(0, NREQ - 1));
      transact($urandom_range(1, 8), 0, 1'b0);
    end
    req = '0;

    // ALU never acknowledges on port 1, then a normal op keeps the sticky flag.
    load_rand(1);
    transact(1, 1, 1'b0);
    load_rand(0);
    transact(3, 0, 1'b0);

    // Ack stuck high before the grant: only a fresh rise completes.
    alu_ans = 32'hDEAD_BEEF;
    alu_ack = 1'b1;
    tick();
    tick();
    load(0, ALU_XOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0);
    transact(4, 2, 1'b0);

    // Reset during WAIT; the late ack must not produce a done.
    load(1, ALU_OR, 32'h1234_0000, 32'h0000_5678, 1'b0);
    tick();
    check("r5_run", alu_run, 1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("r5_gnt", gnt, 0);
    check("r5_done", done, 0);
    check("r5_busy", busy, 0);
    check("r5_run_low", alu_run, 0);
    check("r5_op", alu_op, 0);
    check("r5_opr1", alu_opr1, 0);
    check("r5_opr2", alu_opr2, 0);
    check("r5_c", alu_c, 0);
    check("r5_ans", ans, 0);
    check("r5_terr", timeout_err, 0);
    terr_m = 1'b0;
    ptr_m  = 0;
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    alu_ans = 32'hCAFE_F00D;
    alu_ack = 1'b1;
    begin
      bit late = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        late |= (done != '0) || busy;
      end
      check("r5_no_done", late, 0);
    end
    alu_ack = 1'b0;
    tick();
    load_rand(0);
    load_rand(1);
    transact(2, 0, 1'b0);
    transact(3, 0, 1'b0);
    req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
